// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: fetches 16-bit words, gathers the LDM immediate, hands one instruction per handshake to decode.
// Optional halt support is built when the IFU_HALT_EN macro is defined.
module instr_fetch_issue #(
    parameter int              ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [4:0]      LDM_OPCODE = 5'b00001,
    parameter logic [4:0]      HLT_OPCODE = 5'b11111
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [15:0]       imem_data,
    input  logic              imem_valid,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [4:0]        op_code,
    output logic [2:0]        rdst,
    output logic [2:0]        rsrc,
    output logic [15:0]       imm,
    output logic              ldm_en,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

`ifdef IFU_HALT_EN
    typedef enum logic [1:0] {FETCH, IMM, ISSUE, HALT} state_t;
`else
    typedef enum logic [1:0] {FETCH, IMM, ISSUE} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] pc;

    assign imem_addr = pc;

`ifndef IFU_HALT_EN
    // Without halt support the halt opcode is an ordinary instruction.
    logic unused_hlt;
    assign unused_hlt = (op_code == HLT_OPCODE);
    assign halted     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_rd     <= 1'b0;
            issue_valid <= 1'b0;
            op_code     <= '0;
            rdst        <= '0;
            rsrc        <= '0;
            imm         <= '0;
            ldm_en      <= 1'b0;
            pc_out      <= '0;
`ifdef IFU_HALT_EN
            halted      <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    // The request is raised first; returns are only taken while it is up.
                    if (!imem_rd) begin
                        imem_rd <= 1'b1;
                    end else if (imem_valid) begin
                        op_code <= imem_data[15:11];
                        rdst    <= imem_data[10:8];
                        rsrc    <= imem_data[7:5];
                        imm     <= '0;
                        pc_out  <= pc;
                        pc      <= pc + ADDR_W'(1);
                        if (imem_data[15:11] == LDM_OPCODE) begin
                            state <= IMM;
                        end else begin
                            imem_rd     <= 1'b0;
                            issue_valid <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                IMM: begin
                    if (imem_valid) begin
                        imm         <= imem_data;
                        pc          <= pc + ADDR_W'(1);
                        imem_rd     <= 1'b0;
                        issue_valid <= 1'b1;
                        ldm_en      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        ldm_en      <= 1'b0;
`ifdef IFU_HALT_EN
                        if (op_code == HLT_OPCODE) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            imem_rd <= 1'b1;
                            state   <= FETCH;
                        end
`else
                        imem_rd <= 1'b1;
                        state   <= FETCH;
`endif
                    end
                end
`ifdef IFU_HALT_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue: a vector table for the main program plus hand sequences for PC wrap and reset abort.
module tb_instr_fetch_issue;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: RESET_PC = 0, DUT B: RESET_PC = 1023 for the wrap case.
    logic        rst_a, rst_b;
    logic [9:0]  addr_a, addr_b, pc_out_a, pc_out_b;
    logic        rd_a, rd_b, mem_en_a, mem_en_b;
    logic [15:0] data_a, data_b, imm_a, imm_b;
    logic        iv_a, iv_b, ready_a, ready_b;
    logic [4:0]  op_a, op_b;
    logic [2:0]  rdst_a, rdst_b, rsrc_a, rsrc_b;
    logic        ldm_a, ldm_b, halted_a, halted_b;

    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];

    // Memory returns data combinationally; the valid strobe is left up independent of the request.
    assign data_a = mem_a[addr_a];
    assign data_b = mem_b[addr_b];

    instr_fetch_issue #(.ADDR_W(10), .RESET_PC(10'd0)) dut_a (
        .clk(clk), .rst_n(rst_a), .imem_addr(addr_a), .imem_rd(rd_a),
        .imem_data(data_a), .imem_valid(mem_en_a), .issue_valid(iv_a),
        .issue_ready(ready_a), .op_code(op_a), .rdst(rdst_a), .rsrc(rsrc_a),
        .imm(imm_a), .ldm_en(ldm_a), .pc_out(pc_out_a), .halted(halted_a)
    );

    instr_fetch_issue #(.ADDR_W(10), .RESET_PC(10'd1023)) dut_b (
        .clk(clk), .rst_n(rst_b), .imem_addr(addr_b), .imem_rd(rd_b),
        .imem_data(data_b), .imem_valid(mem_en_b), .issue_valid(iv_b),
        .issue_ready(ready_b), .op_code(op_b), .rdst(rdst_b), .rsrc(rsrc_b),
        .imm(imm_b), .ldm_en(ldm_b), .pc_out(pc_out_b), .halted(halted_b)
    );

    typedef struct packed {
        logic [15:0] word;
        logic [3:0]  mem_wait;
        logic [3:0]  lat;
        logic [3:0]  hold;
        logic [4:0]  op;
        logic [2:0]  rdst;
        logic [2:0]  rsrc;
        logic [15:0] imm;
        logic        ldm;
        logic [9:0]  pc_out;
        logic [9:0]  next_addr;
    } vec_t;

`ifdef IFU_HALT_EN
    localparam int NV = 5;
`else
    localparam int NV = 6;
`endif

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int i);
        int cnt;
        vec_t v;
        v = vecs[i];
        if (v.mem_wait != 0) begin
            mem_en_a = 1'b0;
            ready_a  = 1'b1;
            for (int w = 0; w < int'(v.mem_wait); w++) begin
                @(negedge clk);
                check_output("wait_rd", {31'd0, rd_a}, 32'd1);
                check_output("wait_addr", {22'd0, addr_a}, {22'd0, v.pc_out});
                check_output("wait_iv", {31'd0, iv_a}, 32'd0);
            end
            ready_a  = 1'b0;
            mem_en_a = 1'b1;
        end
        cnt = 0;
        while (!iv_a && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_output("issue_valid", {31'd0, iv_a}, 32'd1);
        check_output("latency", cnt, {28'd0, v.lat});
        check_output("op_code", {27'd0, op_a}, {27'd0, v.op});
        check_output("rdst", {29'd0, rdst_a}, {29'd0, v.rdst});
        check_output("rsrc", {29'd0, rsrc_a}, {29'd0, v.rsrc});
        check_output("imm", {16'd0, imm_a}, {16'd0, v.imm});
        check_output("ldm_en", {31'd0, ldm_a}, {31'd0, v.ldm});
        check_output("pc_out", {22'd0, pc_out_a}, {22'd0, v.pc_out});
        for (int h = 0; h < int'(v.hold); h++) begin
            @(negedge clk);
            check_output("hold_iv", {31'd0, iv_a}, 32'd1);
            check_output("hold_op", {27'd0, op_a}, {27'd0, v.op});
            check_output("hold_rd", {31'd0, rd_a}, 32'd0);
            check_output("hold_addr", {22'd0, addr_a}, {22'd0, v.next_addr});
        end
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        check_output("post_iv", {31'd0, iv_a}, 32'd0);
        check_output("post_ldm", {31'd0, ldm_a}, 32'd0);
`ifdef IFU_HALT_EN
        if (v.op == 5'h1F) begin
            check_output("halted", {31'd0, halted_a}, 32'd1);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                check_output("halt_rd", {31'd0, rd_a}, 32'd0);
                check_output("halt_iv", {31'd0, iv_a}, 32'd0);
            end
            return;
        end
`endif
        check_output("halted0", {31'd0, halted_a}, 32'd0);
        check_output("next_rd", {31'd0, rd_a}, 32'd1);
        check_output("next_addr", {22'd0, addr_a}, {22'd0, v.next_addr});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0;
        mem_en_a = 1'b1; mem_en_b = 1'b1;
        for (int j = 0; j < 1024; j++) begin
            mem_a[j] = 16'h0000;
            mem_b[j] = 16'h0000;
        end
        //          word      wait  lat   hold  op     rdst  rsrc  imm        ldm   pc_out  next
        vecs[0] = '{16'h2120, 4'd0, 4'd1, 4'd0, 5'h04, 3'd1, 3'd1, 16'h0000, 1'b0, 10'd0, 10'd1};
        vecs[1] = '{16'h0A00, 4'd0, 4'd2, 4'd0, 5'h01, 3'd2, 3'd0, 16'hBEEF, 1'b1, 10'd1, 10'd3};
        vecs[2] = '{16'h3B40, 4'd0, 4'd1, 4'd5, 5'h07, 3'd3, 3'd2, 16'h0000, 1'b0, 10'd3, 10'd4};
        vecs[3] = '{16'h5CE0, 4'd3, 4'd1, 4'd0, 5'h0B, 3'd4, 3'd7, 16'h0000, 1'b0, 10'd4, 10'd5};
        vecs[4] = '{16'hF800, 4'd0, 4'd1, 4'd0, 5'h1F, 3'd0, 3'd0, 16'h0000, 1'b0, 10'd5, 10'd6};
        vecs[5] = '{16'h0FFF, 4'd0, 4'd2, 4'd0, 5'h01, 3'd7, 3'd7, 16'h0000, 1'b1, 10'd6, 10'd8};
        for (int j = 0; j < 6; j++) begin
            mem_a[vecs[j].pc_out] = vecs[j].word;
            if (vecs[j].ldm) mem_a[vecs[j].pc_out + 10'd1] = vecs[j].imm;
        end
        mem_b[1023] = 16'h0C40;
        mem_b[0]    = 16'h1234;
        mem_b[1]    = 16'h2120;

        $display("[TB] reset state");
        @(negedge clk); @(negedge clk);
        check_output("rst_rd", {31'd0, rd_a}, 32'd0);
        check_output("rst_iv", {31'd0, iv_a}, 32'd0);
        check_output("rst_addr", {22'd0, addr_a}, 32'd0);
        check_output("rst_op", {27'd0, op_a}, 32'd0);
        check_output("rst_imm", {16'd0, imm_a}, 32'd0);
        check_output("rst_halted", {31'd0, halted_a}, 32'd0);

        $display("[TB] vector table");
        rst_a = 1'b1;
        @(negedge clk);
        check_output("first_rd", {31'd0, rd_a}, 32'd1);
        check_output("first_addr", {22'd0, addr_a}, 32'd0);
        check_output("first_iv", {31'd0, iv_a}, 32'd0);
        for (int i = 0; i < NV; i++) apply_stimulus(i);

        $display("[TB] wrap sequence");
        check_output("b_rst_addr", {22'd0, addr_b}, 32'd1023);
        check_output("b_rst_rd", {31'd0, rd_b}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        check_output("b_req_rd", {31'd0, rd_b}, 32'd1);
        check_output("b_req_addr", {22'd0, addr_b}, 32'd1023);
        @(negedge clk);
        check_output("b_imm_rd", {31'd0, rd_b}, 32'd1);
        check_output("b_imm_addr", {22'd0, addr_b}, 32'd0);
        check_output("b_imm_iv", {31'd0, iv_b}, 32'd0);
        @(negedge clk);
        check_output("b_iv", {31'd0, iv_b}, 32'd1);
        check_output("b_op", {27'd0, op_b}, 32'd1);
        check_output("b_rdst", {29'd0, rdst_b}, 32'd4);
        check_output("b_rsrc", {29'd0, rsrc_b}, 32'd2);
        check_output("b_imm", {16'd0, imm_b}, 32'h1234);
        check_output("b_ldm", {31'd0, ldm_b}, 32'd1);
        check_output("b_pc_out", {22'd0, pc_out_b}, 32'd1023);
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        check_output("b_next_addr", {22'd0, addr_b}, 32'd1);
        check_output("b_next_rd", {31'd0, rd_b}, 32'd1);
        @(negedge clk);
        check_output("b2_iv", {31'd0, iv_b}, 32'd1);
        check_output("b2_op", {27'd0, op_b}, 32'd4);
        check_output("b2_pc_out", {22'd0, pc_out_b}, 32'd1);
        check_output("b2_imm", {16'd0, imm_b}, 32'd0);

        $display("[TB] reset during IMM");
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("c_imm_addr", {22'd0, addr_b}, 32'd0);
        check_output("c_imm_op", {27'd0, op_b}, 32'd1);
        #2 rst_b = 1'b0;
        #1;
        check_output("c_rst_rd", {31'd0, rd_b}, 32'd0);
        check_output("c_rst_iv", {31'd0, iv_b}, 32'd0);
        check_output("c_rst_op", {27'd0, op_b}, 32'd0);
        check_output("c_rst_rdst", {29'd0, rdst_b}, 32'd0);
        check_output("c_rst_pc_out", {22'd0, pc_out_b}, 32'd0);
        check_output("c_rst_addr", {22'd0, addr_b}, 32'd1023);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check_output("c_req_rd", {31'd0, rd_b}, 32'd1);
        check_output("c_req_addr", {22'd0, addr_b}, 32'd1023);
        check_output("c_req_iv", {31'd0, iv_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
